// File: rtl/mem_hs_param.sv
// -----------------------------------------------------------------------------
// mem_hs_param
//   Parametrised single-port data memory. It accepts a read or a write request
//   in IDLE, waits WAIT_STATES extra cycles, performs the access and signals
//   completion with a one-cycle readyMem pulse. Malformed requests get a
//   one-cycle err pulse. acc_count counts completed accesses and wraps.
//
// Ports
//   clk         in   1       clock, rising edge
//   rst         in   1       synchronous reset, active-high
//   rd          in   1       read request (sampled only in IDLE)
//   wr          in   1       write request (sampled only in IDLE)
//   addressBus  in   ADDR_W  word address, latched on acceptance
//   writeData   in   DATA_W  write data, latched on acceptance
//   readData    out  DATA_W  registered read data, held until next read completes
//   readyMem    out  1       one-cycle completion pulse
//   busy        out  1       request in flight (WAIT or ACK)
//   err         out  1       one-cycle pulse on a rejected request
//   acc_count   out  CNT_W   completed-access counter, wraps
// -----------------------------------------------------------------------------
module mem_hs_param #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 5,
   parameter int DEPTH       = 32,
   parameter int WAIT_STATES = 1,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addressBus,
   input  logic [DATA_W-1:0] writeData,
   output logic [DATA_W-1:0] readData,
   output logic              readyMem,
   output logic              busy,
   output logic              err,
   output logic [CNT_W-1:0]  acc_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;

   // One extra bit so DEPTH == 2**ADDR_W is representable in the compare.
   localparam logic [ADDR_W:0] DEPTH_LIM  = (ADDR_W+1)'(DEPTH);
   localparam logic [3:0]      WAIT_LOAD  = 4'(WAIT_STATES);

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              op_wr_q, op_wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  acc_q, acc_d;
   logic              do_access;
   logic              addr_ok;

   logic [DATA_W-1:0] mem_q [DEPTH];

   assign addr_ok = ({1'b0, addressBus} < DEPTH_LIM);

   // NOTE: every variable gets a default at the top of always_comb so no path
   // leaves it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_wr_d   = op_wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      ready_d   = 1'b0;
      err_d     = 1'b0;
      do_access = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rd || wr) begin
               if ((rd && wr) || !addr_ok) begin
                  err_d = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  op_wr_d = wr;
                  addr_d  = addressBus;
                  wdata_d = writeData;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d   = S_ACK;
               ready_d   = 1'b1;
               do_access = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from next-state values so they line up with
      // the state they describe without any input-to-output combinational path.
      busy_d  = (state_d != S_IDLE);
      acc_d   = do_access ? acc_q + CNT_W'(1) : acc_q;
      rdata_d = (do_access && !op_wr_q) ? mem_q[addr_q] : rdata_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_wr_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_wr_q <= op_wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         acc_q   <= acc_d;
      end
   end

   // NOTE: the storage must read back as zero after reset, so it is built from
   // resettable flops rather than a RAM macro; keep DEPTH modest.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (do_access && op_wr_q) begin
         mem_q[addr_q] <= wdata_q;
      end
   end

   assign readData  = rdata_q;
   assign readyMem  = ready_q;
   assign busy      = busy_q;
   assign err       = err_q;
   assign acc_count = acc_q;

endmodule
